// File: rtl/dice_pkg.sv
// Shared constants, float helpers and FSM encoding for the DIC subset path.
// Imported by float_to_index and subset_pixel_fetch.
package dice_pkg;

    localparam int N_POINTS   = 9;
    localparam int IMG_WIDTH  = 448;
    localparam int IMG_HEIGHT = 232;
    localparam int PIX_W      = 8;
    localparam int ADDR_W     = 17;

    localparam logic [31:0] FLOAT_ONE = 32'h3F80_0000;
    localparam int          EXP_BIAS  = 127;
    localparam int          MAX_EXP   = 15;
    localparam int          IDX_W     = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CONV  = 3'd1,
        S_ADDR  = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/float_to_index.sv
// Single-precision float to truncated 16-bit unsigned index (combinational).
// Ports: f (float in), idx (integer part), oob (value not representable).
module float_to_index
    import dice_pkg::*;
(
    input  logic [31:0]      f,
    output logic [IDX_W-1:0] idx,
    output logic             oob
);

    logic        sign;
    logic [7:0]  expo;
    logic [23:0] sig;
    logic [4:0]  sh;

    assign sign = f[31];
    assign expo = f[30:23];
    assign sig  = {1'b1, f[22:0]};

    // Right shift of 23 - (expo - bias); only used for expo 127..142,
    // where it ranges 23..8, so the result always fits in 16 bits.
    assign sh = 5'(8'(EXP_BIAS + 23) - expo);

    always_comb begin
        idx = '0;
        oob = 1'b0;
        if (expo < 8'(EXP_BIAS)) begin
            // |v| < 1 (including +-0 and denormals) truncates to 0
            idx = '0;
        end else if (sign) begin
            oob = 1'b1;
        end else if (expo == 8'hFF) begin
            oob = 1'b1;
        end else if (expo > 8'(EXP_BIAS + MAX_EXP)) begin
            oob = 1'b1;
        end else begin
            idx = IDX_W'(sig >> sh);
        end
    end

endmodule

// File: rtl/subset_pixel_fetch.sv
// Converts a subset's float coordinates to pixel addresses and reads them.
// Ports: clock/reset, x/y coords, sub_done start level, pixel memory
// read port, packed pixels, oob_mask, fetch_done level.
module subset_pixel_fetch #(
    parameter int N_POINTS   = dice_pkg::N_POINTS,
    parameter int IMG_WIDTH  = dice_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = dice_pkg::IMG_HEIGHT,
    parameter int PIX_W      = dice_pkg::PIX_W,
    parameter int ADDR_W     = dice_pkg::ADDR_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_POINTS*32-1:0]    x,
    input  logic [N_POINTS*32-1:0]    y,
    input  logic                      sub_done,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_rd_en,
    input  logic [PIX_W-1:0]          mem_rd_data,
    input  logic                      mem_rd_valid,
    output logic [N_POINTS*PIX_W-1:0] pixels,
    output logic [N_POINTS-1:0]       oob_mask,
    output logic                      fetch_done
);

    import dice_pkg::*;

    localparam int K_W = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
    localparam logic [K_W-1:0] LAST = K_W'(N_POINTS - 1);

    state_t                 state;
    logic [K_W-1:0]         k;
    logic                   sub_q;
    logic                   start;
    logic [N_POINTS*32-1:0] x_lat;
    logic [N_POINTS*32-1:0] y_lat;
    logic [31:0]            cv_in;
    logic [IDX_W-1:0]       cv_idx;
    logic                   cv_oob;
    logic [IDX_W-1:0]       x_int;
    logic                   x_oob;
    logic                   pt_oob;
    logic [ADDR_W-1:0]      addr_calc;

    assign start = sub_done & ~sub_q;

    // One converter: x in CONV (registered), y in ADDR (used directly).
    assign cv_in = (state == S_CONV) ? x_lat[int'(k)*32 +: 32]
                                     : y_lat[int'(k)*32 +: 32];

    float_to_index u_cvt (
        .f   (cv_in),
        .idx (cv_idx),
        .oob (cv_oob)
    );

    assign pt_oob = x_oob | cv_oob
                  | (x_int  >= IDX_W'(IMG_WIDTH))
                  | (cv_idx >= IDX_W'(IMG_HEIGHT));

    assign addr_calc = ADDR_W'(32'(cv_idx) * 32'(IMG_WIDTH) + 32'(x_int));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            k          <= '0;
            sub_q      <= 1'b0;
            x_lat      <= '0;
            y_lat      <= '0;
            x_int      <= '0;
            x_oob      <= 1'b0;
            mem_addr   <= '0;
            mem_rd_en  <= 1'b0;
            pixels     <= '0;
            oob_mask   <= '0;
            fetch_done <= 1'b0;
        end else begin
            sub_q     <= sub_done;
            mem_rd_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_lat      <= x;
                        y_lat      <= y;
                        k          <= '0;
                        pixels     <= '0;
                        oob_mask   <= '0;
                        fetch_done <= 1'b0;
                        state      <= S_CONV;
                    end
                end
                S_CONV: begin
                    x_int <= cv_idx;
                    x_oob <= cv_oob;
                    state <= S_ADDR;
                end
                S_ADDR: begin
                    if (pt_oob) begin
                        oob_mask[k] <= 1'b1;
                        state       <= S_NEXT;
                    end else begin
                        mem_addr  <= addr_calc;
                        mem_rd_en <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rd_valid) begin
                        pixels[int'(k)*PIX_W +: PIX_W] <= mem_rd_data;
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (k == LAST) begin
                        fetch_done <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        k     <= k + 1'b1;
                        state <= S_CONV;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subset_pixel_fetch.sv
// Self-checking bench for subset_pixel_fetch: vector table, corner
// sequences and randomized fetches against a real-arithmetic model.
module tb_subset_pixel_fetch;

    localparam int NP = 9;
    localparam int W  = 448;
    localparam int H  = 232;

    logic              clock = 1'b0;
    logic              reset;
    logic [NP*32-1:0]  xs;
    logic [NP*32-1:0]  ys;
    logic              sub_done;
    logic [16:0]       mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_rd_data;
    logic              mem_rd_valid;
    logic [NP*8-1:0]   pixels;
    logic [NP-1:0]     oob_mask;
    logic              fetch_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;
    int spur_at  = -1;

    int          req_due[$];
    logic [16:0] req_addr[$];
    logic [16:0] addr_log[$];
    int          exp_addr[$];

    subset_pixel_fetch dut (
        .clock        (clock),
        .reset        (reset),
        .x            (xs),
        .y            (ys),
        .sub_done     (sub_done),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid),
        .pixels       (pixels),
        .oob_mask     (oob_mask),
        .fetch_done   (fetch_done)
    );

    always #5 clock = ~clock;

    // Memory model: requests seen in cycle c answer in cycle c+lat
    // with the low address byte as the gray level.
    always @(negedge clock) begin
        if (mem_rd_en === 1'b1) begin
            req_addr.push_back(mem_addr);
            req_due.push_back(cyc + lat);
            addr_log.push_back(mem_addr);
        end
    end

    always @(posedge clock) begin
        cyc++;
        #1;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        while (req_due.size() > 0 && req_due[0] < cyc) begin
            void'(req_due.pop_front());
            void'(req_addr.pop_front());
        end
        if (req_due.size() > 0 && req_due[0] == cyc) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = req_addr[0][7:0];
            void'(req_due.pop_front());
            void'(req_addr.pop_front());
        end else if (spur_at == cyc) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 8'hEE;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] to_f32(input real r);
        logic [63:0] b;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic real f32_to_real(input logic [31:0] f);
        logic [10:0] e;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'h0});
    endfunction

    function automatic void conv(input logic [31:0] f, output int v,
                                 output bit oob);
        real r;
        v   = 0;
        oob = 1'b0;
        if (f[30:23] < 8'd127) return;
        if (f[31] || f[30:23] == 8'hFF) begin
            oob = 1'b1;
            return;
        end
        r = f32_to_real(f);
        if (r >= 65536.0) oob = 1'b1;
        else v = $rtoi(r);
    endfunction

    function automatic void model(input logic [NP*32-1:0] xv,
                                  input logic [NP*32-1:0] yv,
                                  input int l,
                                  output logic [NP*8-1:0] px,
                                  output logic [NP-1:0] om,
                                  output int off);
        int xi, yi, a;
        bit xo, yo;
        px  = '0;
        om  = '0;
        off = 1;
        exp_addr.delete();
        for (int k = 0; k < NP; k++) begin
            conv(xv[k*32 +: 32], xi, xo);
            conv(yv[k*32 +: 32], yi, yo);
            if (xo || yo || xi >= W || yi >= H) begin
                om[k] = 1'b1;
                off  += 3;
            end else begin
                a = yi * W + xi;
                exp_addr.push_back(a);
                px[k*8 +: 8] = a[7:0];
                off += l + 4;
            end
        end
    endfunction

    function automatic logic [31:0] rand_coord(input int lim);
        int sel;
        real r;
        sel = $urandom_range(0, 9);
        if (sel < 7) begin
            r = real'($urandom_range(0, lim - 1))
              + real'($urandom_range(0, 63)) / 64.0;
            return to_f32(r);
        end
        if (sel == 7) return $urandom;
        if (sel == 8) return to_f32(real'(lim + $urandom_range(0, 100)));
        return 32'h8000_0000 | to_f32(real'($urandom_range(1, 50)));
    endfunction

    task automatic run_fetch(input string nm,
                             input logic [NP*32-1:0] xv,
                             input logic [NP*32-1:0] yv,
                             input int l, input bit spur, input bit hold,
                             output int done_off);
        logic [NP*8-1:0] epx;
        logic [NP-1:0]   eom;
        int              eoff;
        int              c0;
        model(xv, yv, l, epx, eom, eoff);
        @(posedge clock);
        #2;
        xs       = xv;
        ys       = yv;
        lat      = l;
        addr_log.delete();
        sub_done = 1'b1;
        c0       = cyc;
        spur_at  = spur ? c0 + 2 : -1;
        @(posedge clock);
        #2;
        for (int i = 0; i < NP; i++) begin
            xs[i*32 +: 32] = $urandom;
            ys[i*32 +: 32] = $urandom;
        end
        if (hold) begin
            sub_done = 1'b0;
            @(posedge clock);
            #2;
            sub_done = 1'b1;
        end
        done_off = -1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clock);
            if (fetch_done === 1'b1) begin
                done_off = cyc - c0;
                break;
            end
        end
        check({nm, ".done_cycle"}, done_off, eoff);
        check({nm, ".oob_mask"}, oob_mask, eom);
        check({nm, ".pixels"}, pixels, epx);
        check({nm, ".n_reads"}, addr_log.size(), exp_addr.size());
        for (int i = 0; i < addr_log.size() && i < exp_addr.size(); i++)
            check($sformatf("%s.addr%0d", nm, i), addr_log[i], exp_addr[i]);
        @(negedge clock);
        check({nm, ".stable_done"}, fetch_done, 1'b1);
        check({nm, ".stable_pixels"}, pixels, epx);
        if (!hold) sub_done = 1'b0;
    endtask

    typedef struct {
        logic [31:0] x0;
        logic [31:0] y0;
        logic        oob;
        logic [16:0] addr;
        int          done;
    } vec_t;

    vec_t            vt[12];
    logic [NP*32-1:0] bx, by, xv, yv;
    int              doff;
    int              nr;

    initial begin
        vt[0]  = '{32'h4080_0000, 32'h4080_0000, 1'b0, 17'd1796,   46};
        vt[1]  = '{32'h4070_0000, 32'h3F00_0000, 1'b0, 17'd3,      46};
        vt[2]  = '{32'h0000_0000, 32'h8000_0000, 1'b0, 17'd0,      46};
        vt[3]  = '{32'hBF80_0000, 32'h3F80_0000, 1'b1, 17'd0,      44};
        vt[4]  = '{32'h7F80_0000, 32'h3F80_0000, 1'b1, 17'd0,      44};
        vt[5]  = '{32'h7FC0_0000, 32'h3F80_0000, 1'b1, 17'd0,      44};
        vt[6]  = '{32'h4780_0000, 32'h0000_0000, 1'b1, 17'd0,      44};
        vt[7]  = '{32'h43DF_8000, 32'h4367_0000, 1'b0, 17'd103935, 46};
        vt[8]  = '{32'h43E0_0000, 32'h0000_0000, 1'b1, 17'd0,      44};
        vt[9]  = '{32'h0000_0000, 32'h4368_0000, 1'b1, 17'd0,      44};
        vt[10] = '{32'h3F7F_FFFF, 32'h3FC0_0000, 1'b0, 17'd448,    46};
        vt[11] = '{32'h477F_FF00, 32'h3F80_0000, 1'b1, 17'd0,      44};

        for (int k = 0; k < NP; k++) begin
            bx[k*32 +: 32] = to_f32(real'(k * 50) + 0.25);
            by[k*32 +: 32] = to_f32(real'(k * 25) + 0.75);
        end

        reset        = 1'b1;
        sub_done     = 1'b0;
        xs           = '0;
        ys           = '0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        repeat (3) @(posedge clock);
        #2;
        check("reset.mem_addr", mem_addr, 0);
        check("reset.mem_rd_en", mem_rd_en, 0);
        check("reset.pixels", pixels, 0);
        check("reset.oob_mask", oob_mask, 0);
        check("reset.fetch_done", fetch_done, 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            xv = bx;
            yv = by;
            xv[31:0] = vt[i].x0;
            yv[31:0] = vt[i].y0;
            run_fetch($sformatf("vec%0d", i), xv, yv, 1, 1'b0, 1'b0, doff);
            check($sformatf("vec%0d.tbl_done", i), doff, vt[i].done);
            check($sformatf("vec%0d.tbl_oob0", i), oob_mask[0], vt[i].oob);
            check($sformatf("vec%0d.tbl_pix0", i), pixels[7:0],
                  vt[i].oob ? 8'h00 : vt[i].addr[7:0]);
            if (!vt[i].oob && addr_log.size() > 0)
                check($sformatf("vec%0d.tbl_addr0", i), addr_log[0],
                      vt[i].addr);
        end

        xv = bx;
        xv[2*32 +: 32] = 32'hBF80_0000;
        xv[5*32 +: 32] = 32'h43E0_0000;
        run_fetch("oob25", xv, by, 1, 1'b0, 1'b0, doff);
        check("oob25.mask_const", oob_mask, 9'h024);
        check("oob25.reads_const", addr_log.size(), 7);
        check("oob25.pix2", pixels[23:16], 0);
        check("oob25.pix5", pixels[47:40], 0);

        run_fetch("lat5", bx, by, 5, 1'b1, 1'b0, doff);
        check("lat5.done_const", doff, 82);

        // Abort during the WAIT of point 4; its response arrives late.
        @(posedge clock);
        #2;
        xs       = bx;
        ys       = by;
        lat      = 5;
        spur_at  = -1;
        addr_log.delete();
        sub_done = 1'b1;
        for (int n = 0; n < 500 && addr_log.size() < 5; n++) begin
            @(posedge clock);
            #2;
        end
        check("rst.reached_pt4", addr_log.size(), 5);
        reset    = 1'b1;
        sub_done = 1'b0;
        #1;
        check("rst.mem_rd_en", mem_rd_en, 0);
        check("rst.mem_addr", mem_addr, 0);
        check("rst.pixels", pixels, 0);
        check("rst.oob_mask", oob_mask, 0);
        check("rst.fetch_done", fetch_done, 0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        nr = addr_log.size();
        repeat (8) @(negedge clock);
        check("rst.late_pixels", pixels, 0);
        check("rst.late_done", fetch_done, 0);
        check("rst.no_reads", addr_log.size(), nr);
        run_fetch("after_rst", bx, by, 2, 1'b0, 1'b0, doff);

        // Held-high start level: one fetch, no restart until low then high.
        run_fetch("hold1", bx, by, 1, 1'b0, 1'b1, doff);
        nr = addr_log.size();
        repeat (20) @(negedge clock);
        check("hold.no_refetch", addr_log.size(), nr);
        check("hold.done_level", fetch_done, 1'b1);
        sub_done = 1'b0;
        repeat (2) @(negedge clock);
        run_fetch("hold2", by, bx, 1, 1'b0, 1'b0, doff);

        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < NP; i++) begin
                xv[i*32 +: 32] = rand_coord(W);
                yv[i*32 +: 32] = rand_coord(H);
            end
            run_fetch($sformatf("rand%0d", t), xv, yv,
                      $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                      1'b0, doff);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/subset_pixel_fetch.md
# subset_pixel_fetch

Downstream stage of the subset coordinate generator. Takes the packed IEEE-754 single-precision x/y coordinate arrays for one correlation subset and converts each point to an integer pixel index. For each in-range point it issues one read to the reference-image pixel memory, then packs the returned gray levels for the correlation core. Points that fall outside the image are flagged and never read.

## Interface
Parameters:
- N_POINTS, 9: coordinates per subset (array width N_POINTS×32)
- IMG_WIDTH, 448: image columns (x range 0..IMG_WIDTH-1)
- IMG_HEIGHT, 232: image rows (y range 0..IMG_HEIGHT-1)
- PIX_W, 8: gray-level width
- ADDR_W, 17: pixel memory address width (≥ clog2(IMG_WIDTH×IMG_HEIGHT))

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- x  in  N_POINTS×32  packed float x coords, point k at [k*32+:32]
- y  in  N_POINTS×32  packed float y coords, same packing
- sub_done  in  1  upstream level; a rising edge starts one fetch
- mem_addr  out  ADDR_W  pixel address = y_int×IMG_WIDTH + x_int
- mem_rd_en  out  1  one-cycle read request
- mem_rd_data  in  PIX_W  returned pixel
- mem_rd_valid  in  1  mem_rd_data valid this cycle
- pixels  out  N_POINTS×PIX_W  point k at [k*PIX_W+:PIX_W]
- oob_mask  out  N_POINTS  bit k set = point k outside image
- fetch_done  out  1  level, high from completion until next start

## Operation
- Reset: all outputs 0, FSM IDLE, point index 0, sub_done edge register 0. If sub_done is high in the first cycle after reset, that counts as a rising edge and a fetch starts.
- Start: sub_done high while its registered copy is low, in IDLE. x/y are latched at start; later changes are ignored. A start seen while busy is ignored.
- On start: fetch_done, pixels and oob_mask are cleared.
- FSM states:
  - IDLE: waits for start.
  - CONV: converts point k x/y to integers.
  - ADDR: range check and address multiply. Out of range goes to NEXT; in range goes to ISSUE.
  - ISSUE: mem_rd_en=1 with mem_addr for one cycle.
  - WAIT: stays until mem_rd_valid, then stores the pixel.
  - NEXT: k=N_POINTS-1 goes to DONE, otherwise k+1 and CONV.
  - DONE: fetch_done=1, then IDLE.
- Float→int conversion (truncation toward zero):
  - ±0 or exponent <127 → 0, in range.
  - Sign set with nonzero magnitude → oob.
  - Exponent 255 (Inf/NaN) → oob.
  - Unbiased exponent >15 → oob.
  - Otherwise int = {1,mantissa} >> (23 − e).
  - x_int ≥ IMG_WIDTH or y_int ≥ IMG_HEIGHT → oob.
- OOB point: pixel field stays 0, oob_mask[k]=1, no memory request.
- mem_rd_valid outside WAIT is ignored. mem_addr holds its last value outside ISSUE.

## Timing
- Start edge seen at cycle 0 → CONV for point 0 at cycle 1.
- In-range point, memory latency L ≥ 1 (valid L cycles after ISSUE): CONV, ADDR, ISSUE, then L WAIT cycles, then NEXT = L+4 cycles.
- OOB point: CONV, ADDR, NEXT = 3 cycles.
- fetch_done rises the cycle after the last NEXT. With all 9 points in range and L=1, fetch_done is high at cycle 46.
- pixels/oob_mask are stable whenever fetch_done=1.
- Reset mid-fetch: aborts immediately. Any outstanding memory response is dropped, because after reset the FSM is in IDLE and ignores mem_rd_valid.

## Structure
- Shared package dice_pkg: IMG_WIDTH, IMG_HEIGHT, ADDR_W, PIX_W, N_POINTS, float constants (FLOAT_ONE=0x3F800000, exponent bias 127), and the FSM state encoding.
- One combinational sub-module, float_to_index: 32-bit float in → 16-bit integer plus oob flag out. It is instantiated once and shared by x and y, muxed in CONV.
- Memory model and start-edge detector stay in the top level.

## Test plan
- Point 0 = (4.0 0x40800000, 4.0), other points in range, L=1, memory returns addr[7:0] → mem_addr=1796 on first ISSUE, pixels[7:0]=0x04, oob_mask=0, fetch_done at cycle 46.
- x=3.75 (0x40700000), y=0.5 (0x3F000000) → x_int=3, y_int=0, mem_addr=3.
- Point 2 x=−1.0 (0xBF800000); point 5 x=448.0 (0x43E00000) → oob_mask=0x024, pixel fields 2 and 5 = 0, exactly 7 mem_rd_en pulses.
- L=5 with a spurious mem_rd_valid during ADDR → spurious valid ignored, each in-range point takes 9 cycles, fetch_done at cycle 82.
- reset asserted during WAIT of point 4 → all outputs 0 immediately. A late mem_rd_valid is ignored. A new sub_done edge fetches all 9 points correctly.
- sub_done held high across completion, then low, then high → exactly two fetches, none while busy.
